// File: rtl/ifetch_unit.sv
`default_nettype none
// ifetch_unit: single-issue fetch stage driving the IF/ID register, with a one-entry hold buffer.
// Optional build macro IF_PERF_CNT_EN adds the fetch_count output and its counter.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MIP_BUS  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               Jump,
  input  logic [25:0]        jump_index,
  output logic               imem_req,
  output logic [29:0]        imem_addr,
  input  logic [MIP_BUS-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [MIP_BUS-1:0] Instruction,
  output logic [31:0]        PC_plus4,
  output logic               IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [29:0]        kill_addr_q, kill_addr_d;
  logic [MIP_BUS-1:0] hold_instr_q, hold_instr_d;
  logic [31:0]        hold_pc4_q, hold_pc4_d;
  logic [MIP_BUS-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               load_real;

  logic               redirect;
  logic [31:0]        br_target;
  logic [31:0]        jmp_target;
  logic [31:0]        redir_target;
  logic [31:0]        pc_inc;
  logic               unused_bt_lsbs;

  assign redirect     = (branch_taken | Jump) & ~stall;
  assign br_target    = {branch_target[31:2], 2'b00};
  assign jmp_target   = {pc4_q[31:28], jump_index, 2'b00};
  assign redir_target = branch_taken ? br_target : jmp_target;
  assign pc_inc       = pc_q + 32'd4;
  assign unused_bt_lsbs = ^branch_target[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    load_real    = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          if (!redirect) begin
            pc_d = pc_inc;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_inc;
              state_d      = S_HOLD;
            end else begin
              instr_d   = imem_rdata;
              pc4_d     = pc_inc;
              valid_d   = 1'b1;
              load_real = 1'b1;
            end
          end
        end else if (redirect) begin
          // The in-flight request must stay visible on the bus until memory answers it.
          kill_addr_d = pc_q[31:2];
          state_d     = S_KILL;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      S_KILL: begin
        if (imem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (!redirect) begin
            instr_d   = hold_instr_q;
            pc4_d     = hold_pc4_q;
            valid_d   = 1'b1;
            load_real = 1'b1;
          end
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // A redirect overrides whatever the state logic chose for IF/ID and PC.
    if (redirect) begin
      instr_d   = '0;
      valid_d   = 1'b0;
      pc_d      = redir_target;
      load_real = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC[31:2];
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_KILL);
  assign imem_addr   = (state_q == S_KILL) ? kill_addr_q : pc_q[31:2];
  assign Instruction = instr_q;
  assign PC_plus4    = pc4_q;
  assign IF_valid    = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (load_real) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_load_real;
  assign unused_load_real = load_real;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// tb_ifetch_unit: directed fetch scenarios plus randomized traffic checked against a behavioural model.
module tb_ifetch_unit;

  logic        clk           = 1'b0;
  logic        rst           = 1'b1;
  logic        stall         = 1'b0;
  logic        branch_taken  = 1'b0;
  logic        Jump          = 1'b0;
  logic        imem_ready    = 1'b0;
  logic [31:0] branch_target = '0;
  logic [25:0] jump_index    = '0;

  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata, Instruction, PC_plus4;
  logic        IF_valid;

  logic        d2_req;
  logic [29:0] d2_addr;
  logic [31:0] d2_rdata, d2_instr, d2_pc4;
  logic        d2_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, d2_fetch_count;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = memword(imem_addr);
  assign d2_rdata   = memword(d2_addr);

  ifetch_unit #(.RESET_PC(32'h0000_0000), .MIP_BUS(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Jump(Jump), .jump_index(jump_index),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .Instruction(Instruction), .PC_plus4(PC_plus4),
    .IF_valid(IF_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MIP_BUS(32)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Jump(Jump), .jump_index(jump_index),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_rdata(d2_rdata),
    .imem_ready(imem_ready), .Instruction(d2_instr), .PC_plus4(d2_pc4),
    .IF_valid(d2_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(d2_fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program counter, one outstanding request that may be
  // marked for discard, a one-word stall buffer and the delivered IF/ID contents.
  bit          m_boot     = 1'b1;
  bit          m_drop     = 1'b0;
  bit          m_buf_full = 1'b0;
  bit          m_valid    = 1'b0;
  logic [31:0] m_pc       = '0;
  logic [31:0] m_instr    = '0;
  logic [31:0] m_pc4      = '0;
  logic [31:0] m_buf_instr = '0;
  logic [31:0] m_buf_pc4  = '0;
  logic [31:0] m_cnt      = '0;
  logic [29:0] m_req_addr = '0;

  task automatic model_reset();
    m_boot = 1'b1; m_drop = 1'b0; m_buf_full = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_cnt = '0; m_req_addr = '0;
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] p4);
    m_instr = w; m_pc4 = p4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    logic [29:0] cur;
    redir = (branch_taken | Jump) & ~stall;
    tgt   = branch_taken ? {branch_target[31:2], 2'b00} : {m_pc4[31:28], jump_index, 2'b00};
    cur   = m_drop ? m_req_addr : m_pc[31:2];
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_buf_full) begin
      if (!stall) begin
        if (!redir) deliver(m_buf_instr, m_buf_pc4);
        m_buf_full = 1'b0;
      end
    end else if (imem_ready) begin
      if (m_drop) begin
        m_drop = 1'b0;
      end else if (!redir) begin
        if (stall) begin
          m_buf_instr = memword(cur); m_buf_pc4 = m_pc + 32'd4; m_buf_full = 1'b1;
        end else begin
          deliver(memword(cur), m_pc + 32'd4);
        end
        m_pc = m_pc + 32'd4;
      end
    end else if (!m_drop) begin
      if (redir) begin
        m_drop = 1'b1; m_req_addr = cur;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end
    if (redir) begin
      m_instr = '0; m_valid = 1'b0; m_pc = tgt; m_buf_full = 1'b0;
    end
  endtask

  function automatic logic exp_req();
    return !m_boot && !m_buf_full;
  endfunction

  // Model advances on the falling edge with the inputs that were present at the rising edge.
  initial forever begin
    @(negedge clk);
    if (rst) model_reset(); else model_step();
    chk("model_req",   {31'b0, imem_req}, {31'b0, exp_req()});
    chk("model_addr",  {2'b0, imem_addr}, {2'b0, (m_drop ? m_req_addr : m_pc[31:2])});
    chk("model_instr", Instruction, m_instr);
    chk("model_pc4",   PC_plus4, m_pc4);
    chk("model_valid", {31'b0, IF_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    chk("model_fetch_count", fetch_count, m_cnt);
`endif
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc4",   PC_plus4, 32'h0);
    chk("rst_valid", {31'b0, IF_valid}, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  {2'b0, imem_addr}, 32'h0);
    chk("rst_addr_wrapdut", {2'b0, d2_addr}, 32'h3FFF_FFFF);
    #1 rst = 1'b0; imem_ready = 1'b1;

    @(negedge clk);
    chk("boot_req",   {31'b0, imem_req}, 32'h1);
    chk("boot_addr",  {2'b0, imem_addr}, 32'h0);
    chk("boot_valid", {31'b0, IF_valid}, 32'h0);
    @(negedge clk);
    chk("a0_instr", Instruction, memword(30'd0));
    chk("a0_pc4",   PC_plus4, 32'd4);
    chk("a0_addr",  {2'b0, imem_addr}, 32'd1);
    chk("wrap_addr", {2'b0, d2_addr}, 32'h0);
    chk("wrap_pc4",  d2_pc4, 32'h0);
    @(negedge clk);
    chk("a1_instr", Instruction, memword(30'd1));
    chk("a1_pc4",   PC_plus4, 32'd8);
    chk("a1_addr",  {2'b0, imem_addr}, 32'd2);
    #1 stall = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("hold_req",   {31'b0, imem_req}, 32'h0);
      chk("hold_instr", Instruction, memword(30'd1));
      chk("hold_pc4",   PC_plus4, 32'd8);
    end
    #1 stall = 1'b0;
    @(negedge clk);
    chk("unhold_instr", Instruction, memword(30'd2));
    chk("unhold_pc4",   PC_plus4, 32'd12);
    chk("unhold_addr",  {2'b0, imem_addr}, 32'd3);
    #1 imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0043;

    @(negedge clk);
    chk("kill_req",   {31'b0, imem_req}, 32'h1);
    chk("kill_addr",  {2'b0, imem_addr}, 32'd3);
    chk("kill_valid", {31'b0, IF_valid}, 32'h0);
    #1 branch_taken = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    chk("br_addr",  {2'b0, imem_addr}, 32'h10);
    chk("br_valid", {31'b0, IF_valid}, 32'h0);
    chk("br_instr", Instruction, 32'h0);
    @(negedge clk);
    chk("br_fetch_instr", Instruction, memword(30'h10));
    chk("br_fetch_pc4",   PC_plus4, 32'h44);
    #1 branch_taken = 1'b1; branch_target = 32'h1000_0004;

    @(negedge clk);
    chk("br2_addr", {2'b0, imem_addr}, 32'h0400_0001);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("br2_pc4", PC_plus4, 32'h1000_0008);
    #1 Jump = 1'b1; jump_index = 26'h000_0100;
    @(negedge clk);
    chk("jmp_addr",  {2'b0, imem_addr}, 32'h0400_0100);
    chk("jmp_instr", Instruction, 32'h0);
    chk("jmp_valid", {31'b0, IF_valid}, 32'h0);
    #1 Jump = 1'b0; imem_ready = 1'b0;

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_instr", Instruction, 32'h0);
    chk("arst_pc4",   PC_plus4, 32'h0);
    chk("arst_valid", {31'b0, IF_valid}, 32'h0);
    chk("arst_req",   {31'b0, imem_req}, 32'h0);
    chk("arst_addr",  {2'b0, imem_addr}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    chk("late_ready_valid", {31'b0, IF_valid}, 32'h0);
    chk("late_ready_instr", Instruction, 32'h0);
    chk("late_ready_addr",  {2'b0, imem_addr}, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      rst           = ($urandom_range(0, 299) == 0);
      stall         = ($urandom_range(0, 99) < 20);
      imem_ready    = exp_req() ? ($urandom_range(0, 99) < 65) : ($urandom_range(0, 99) < 5);
      begin
        int r;
        r = int'($urandom_range(0, 99));
        branch_taken = (r < 8);
        Jump         = (r >= 5) && (r < 12);
      end
      branch_target = $urandom;
      jump_index    = 26'($urandom);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the first fetch address.
REQ-002 The parameter MIP_BUS SHALL default to 32 and set the datapath width.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port stall SHALL be input, 1 bit: hazard hold; freezes PC and the IF/ID register.
REQ-006 Port branch_taken SHALL be input, 1 bit: branch resolved taken in decode.
REQ-007 Port branch_target SHALL be input, 32 bits: branch destination byte address.
REQ-008 Port Jump SHALL be input, 1 bit: jump decoded in decode.
REQ-009 Port jump_index SHALL be input, 26 bits: jump instruction bits [25:0].
REQ-010 Port imem_req SHALL be output, 1 bit: instruction-memory request.
REQ-011 Port imem_addr SHALL be output, 30 bits: word address, equal to PC[31:2].
REQ-012 Port imem_rdata SHALL be input, 32 bits: fetched word, valid when imem_ready is 1.
REQ-013 Port imem_ready SHALL be input, 1 bit: request completion, one cycle per request.
REQ-014 Port Instruction SHALL be output, 32 bits: IF/ID instruction register.
REQ-015 Port PC_plus4 SHALL be output, 32 bits: IF/ID register holding the delivered instruction's PC+4.
REQ-016 Port IF_valid SHALL be output, 1 bit: the IF/ID register holds a real instruction.

Function
REQ-017 The block SHALL implement the states BOOT, FETCH, KILL and HOLD.
REQ-018 BOOT SHALL hold imem_req=0 for exactly one cycle, then go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1; imem_req and imem_addr SHALL stay stable until the cycle imem_ready=1.
REQ-020 redirect SHALL equal (branch_taken | Jump) & ~stall; branch_taken SHALL win when both are set.
REQ-021 The branch target SHALL be {branch_target[31:2],2'b00}; the jump target SHALL be {PC_plus4[31:28],jump_index,2'b00}.
REQ-022 FETCH with ready=1, redirect=0, stall=0: Instruction<=imem_rdata, PC_plus4<=PC+4, IF_valid<=1, PC<=PC+4; next state FETCH.
REQ-023 FETCH with ready=1 and stall=1: the word goes to a 1-entry hold buffer, PC<=PC+4, IF/ID unchanged, next state HOLD.
REQ-024 HOLD SHALL drive imem_req=0; when stall falls, the buffer loads into IF/ID (IF_valid<=1) and the next state is FETCH.
REQ-025 On redirect in any state: Instruction<=0, IF_valid<=0, PC<=target, hold buffer discarded.
REQ-026 On redirect in FETCH with ready=0, the next state SHALL be KILL; KILL keeps req/addr stable and discards data at ready, then goes to FETCH with the new PC.
REQ-027 On redirect in FETCH with ready=1, the returned word SHALL be discarded and the next state SHALL be FETCH.
REQ-028 On redirect in HOLD or KILL, the PC update is as REQ-025; KILL stays in KILL until ready.
REQ-029 FETCH with ready=0 and no redirect: IF_valid<=0 when stall=0 (bubble); IF/ID held when stall=1.
REQ-030 PC and PC_plus4 arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 stall=1 SHALL never alter Instruction, PC_plus4 or IF_valid.

Reset
REQ-032 On rst=1 (asynchronous): state=BOOT, PC=RESET_PC, Instruction=0, PC_plus4=0, IF_valid=0, imem_req=0, imem_addr=RESET_PC[31:2], hold buffer empty.
REQ-033 A reset asserted mid-request SHALL abandon the request; a late imem_ready after reset SHALL be ignored.

Configuration
REQ-034 With IF_PERF_CNT_EN defined, a 32-bit output fetch_count SHALL exist: reset 0, +1 on each IF_valid 0/1 load of a real instruction, wraps at 2^32, and holds during stall.
REQ-035 Without IF_PERF_CNT_EN, neither the fetch_count port nor its counter SHALL exist; all other behaviour is unchanged.

Verification
REQ-036 Reset release, imem_ready always 1, words A0,A1 -> imem_addr 0,1,2; Instruction=A0 and then A1; PC_plus4=4 and then 8.
REQ-037 stall=1 for 3 cycles while ready=1 at PC=8 -> HOLD state, imem_req=0, IF/ID frozen; after stall falls, Instruction = the word at address 8.
REQ-038 branch_taken=1, branch_target=32'h0000_0043, with ready=0 -> KILL; at ready the data is dropped, the next imem_addr=0x10, and IF_valid=0 in between.
REQ-039 Jump=1, jump_index=26'h000_0100, PC_plus4=32'h1000_0008 -> next imem_addr=30'h0400_0100 (byte address 0x1000_0400); Instruction=0.
REQ-040 RESET_PC=32'hFFFF_FFFC, ready=1 -> the second imem_addr is 0; rst pulse mid-wait -> all outputs return to reset values immediately.
